// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings and opcode type for the registered
//               ALU (alu_unit) and its add/subtract helper.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode encodings presented on the 3-bit sel port.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    // Typed view of the opcode, used for decoding in the top level.
    typedef enum logic [2:0] {
        ALU_ADD = OP_ADD,
        ALU_SUB = OP_SUB,
        ALU_AND = OP_AND,
        ALU_OR  = OP_OR,
        ALU_XOR = OP_XOR,
        ALU_NOT = OP_NOT,
        ALU_SHL = OP_SHL,
        ALU_SHR = OP_SHR
    } alu_op_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub
// Description : Combinational WIDTH+1-bit adder/subtractor shared by the ADD
//               and SUB opcodes of alu_unit.
// Revision    : 1.0 - initial release
//
// Ports:
//   a              in   WIDTH  operand A
//   b              in   WIDTH  operand B
//   sub            in   1      0 = a + b, 1 = a - b
//   sum            out  WIDTH  low WIDTH bits of the result (mod 2^WIDTH)
//   cout_or_borrow out  1      carry-out for add, borrow (a < b) for subtract
// ============================================================================
module alu_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout_or_borrow
);

    logic [WIDTH:0] w_a_ext;
    logic [WIDTH:0] w_b_ext;
    logic [WIDTH:0] w_result;

    assign w_a_ext = {1'b0, a};
    assign w_b_ext = {1'b0, b};

    // Zero-extending both operands makes bit WIDTH the carry for an add and,
    // because the difference wraps modulo 2^(WIDTH+1), exactly the borrow
    // (set iff a < b) for a subtract.
    assign w_result = sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    assign sum            = w_result[WIDTH-1:0];
    assign cout_or_borrow = w_result[WIDTH];

endmodule : alu_addsub
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_unit
// Description : Registered WIDTH-bit ALU, eight opcodes, one-cycle latency,
//               one operation per cycle, with carry/borrow/shift-out flag.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk        in   1      clock, all state updates on the rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      a, b and sel carry a request this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sel        in   3      opcode (see alu_pkg)
//   y          out  WIDTH  registered result
//   c          out  1      registered carry / borrow / shift-out flag
//   out_valid  out  1      y and c hold the previous cycle's request result
// ============================================================================
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             out_valid
);

    alu_op_t          w_op;
    logic [WIDTH-1:0] w_addsub_sum;
    logic             w_addsub_cout;
    logic [WIDTH-1:0] w_y_next;
    logic             w_c_next;

    logic [WIDTH-1:0] r_y;
    logic             r_c;
    logic             r_out_valid;

    assign w_op = alu_op_t'(sel);

    // One adder serves both ADD and SUB; only sel[0] distinguishes them.
    alu_addsub #(
        .WIDTH          (WIDTH)
    ) u_addsub (
        .a              (a),
        .b              (b),
        .sub            (w_op == ALU_SUB),
        .sum            (w_addsub_sum),
        .cout_or_borrow (w_addsub_cout)
    );

    // Opcode mux. The default branch catches non-2-state opcodes in
    // simulation and registers a clean zero result.
    always_comb begin
        w_y_next = '0;
        w_c_next = 1'b0;
        case (w_op)
            ALU_ADD: begin
                w_y_next = w_addsub_sum;
                w_c_next = w_addsub_cout;
            end
            ALU_SUB: begin
                w_y_next = w_addsub_sum;
                w_c_next = w_addsub_cout;
            end
            ALU_AND: w_y_next = a & b;
            ALU_OR:  w_y_next = a | b;
            ALU_XOR: w_y_next = a ^ b;
            ALU_NOT: w_y_next = ~a;
            ALU_SHL: begin
                w_y_next = {a[WIDTH-2:0], 1'b0};
                w_c_next = a[WIDTH-1];
            end
            ALU_SHR: begin
                w_y_next = {1'b0, a[WIDTH-1:1]};
                w_c_next = a[0];
            end
            default: begin
                w_y_next = '0;
                w_c_next = 1'b0;
            end
        endcase
    end

    // Output register: results load only on a request; idle cycles hold
    // the last result and drop out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y         <= '0;
            r_c         <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_y_next;
                r_c <= w_c_next;
            end
        end
    end

    assign y         = r_y;
    assign c         = r_c;
    assign out_valid = r_out_valid;

endmodule : alu_unit
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_unit
// Description : Directed self-checking bench for alu_unit (WIDTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             out_valid;

    int checks;
    int failures;

    alu_unit #(
        .WIDTH     (WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .y         (y),
        .c         (c),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; a = 4'b0001; b = 4'b0010; sel = 3'b000;
        tick();
        checks++;
        if (y !== 4'b0000 || c !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset: y=%b c=%b ov=%b, required y=0000 c=0 ov=0", y, c, out_valid);
        end
        rst = 1'b0; in_valid = 1'b0;
        tick();
        checks++;
        if (y !== 4'b0000 || c !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: y=%b c=%b ov=%b, required y=0000 c=0 ov=0", y, c, out_valid);
        end
    endtask

    task automatic test_add();
        logic [3:0] va [4] = '{4'b0001, 4'b0010, 4'b1001, 4'b1111};
        logic [3:0] vb [4] = '{4'b0010, 4'b0110, 4'b1010, 4'b0001};
        logic [3:0] ey [4] = '{4'b0011, 4'b1000, 4'b0011, 4'b0000};
        logic       ec [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; sel = 3'b000; a = va[i]; b = vb[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (y !== ey[i] || c !== ec[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL add[%0d]: y=%b c=%b ov=%b, required y=%b c=%b ov=1",
                         i, y, c, out_valid, ey[i], ec[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [3:0] va [3] = '{4'b1111, 4'b0000, 4'b0101};
        logic [3:0] vb [3] = '{4'b1111, 4'b0001, 4'b0011};
        logic [3:0] ey [3] = '{4'b0000, 4'b1111, 4'b0010};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sel = 3'b001; a = va[i]; b = vb[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (y !== ey[i] || c !== ec[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL sub[%0d]: y=%b c=%b ov=%b, required y=%b c=%b ov=1",
                         i, y, c, out_valid, ey[i], ec[i]);
            end
        end
    endtask

    task automatic test_logic();
        logic [2:0] vs [3] = '{3'b010, 3'b011, 3'b100};
        logic [3:0] ey [3] = '{4'b1000, 4'b1011, 4'b0011};
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; sel = vs[i]; a = 4'b1001; b = 4'b1010;
            tick();
            in_valid = 1'b0;
            checks++;
            if (y !== ey[i] || c !== 1'b0 || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL logic[sel=%b]: y=%b c=%b ov=%b, required y=%b c=0 ov=1",
                         vs[i], y, c, out_valid, ey[i]);
            end
        end
    endtask

    task automatic test_not_shift();
        logic [2:0] vs [5] = '{3'b101, 3'b110, 3'b111, 3'b110, 3'b111};
        logic [3:0] va [5] = '{4'b1001, 4'b1001, 4'b1001, 4'b0110, 4'b0110};
        logic [3:0] ey [5] = '{4'b0110, 4'b0010, 4'b0100, 4'b1100, 4'b0011};
        logic       ec [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; sel = vs[i]; a = va[i]; b = 4'b1110;
            tick();
            in_valid = 1'b0;
            checks++;
            if (y !== ey[i] || c !== ec[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL not_shift[%0d sel=%b]: y=%b c=%b ov=%b, required y=%b c=%b ov=1",
                         i, vs[i], y, c, out_valid, ey[i], ec[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        // a=1001, b=1110 through all opcodes 000..111 on consecutive cycles.
        logic [3:0] ey [8] = '{4'b0111, 4'b1011, 4'b1000, 4'b1111,
                               4'b0111, 4'b0110, 4'b0010, 4'b0100};
        logic       ec [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; sel = 3'(i); a = 4'b1001; b = 4'b1110;
            tick();
            checks++;
            if (y !== ey[i] || c !== ec[i] || out_valid !== 1'b1) begin
                failures++;
                $display("FAIL b2b[op=%0d]: y=%b c=%b ov=%b, required y=%b c=%b ov=1",
                         i, y, c, out_valid, ey[i], ec[i]);
            end
        end
        // Bubble: last result (SHR) must hold with out_valid low.
        in_valid = 1'b0; sel = 3'b000; a = 4'b1111; b = 4'b1111;
        tick();
        checks++;
        if (y !== 4'b0100 || c !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bubble_hold: y=%b c=%b ov=%b, required y=0100 c=1 ov=0", y, c, out_valid);
        end
        // Resume the stream.
        in_valid = 1'b1; sel = 3'b000; a = 4'b0011; b = 4'b0100;
        tick();
        in_valid = 1'b0;
        checks++;
        if (y !== 4'b0111 || c !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL resume: y=%b c=%b ov=%b, required y=0111 c=0 ov=1", y, c, out_valid);
        end
    endtask

    task automatic test_unknown_sel();
        // Preload a nonzero result so a clean zero is observable.
        in_valid = 1'b1; sel = 3'b011; a = 4'b1010; b = 4'b0101;
        tick();
        in_valid = 1'b1; sel = 3'bxxx; a = 4'b0000; b = 4'b0000;
        tick();
        in_valid = 1'b0; sel = 3'b000;
        checks++;
        if (y !== 4'b0000 || c !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL unknown_sel: y=%b c=%b ov=%b, required y=0000 c=0 ov=1", y, c, out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        in_valid = 1'b1; sel = 3'b000; a = 4'b0111; b = 4'b0001;
        tick();
        rst = 1'b1; in_valid = 1'b1; sel = 3'b011; a = 4'b1111; b = 4'b1111;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if (y !== 4'b0000 || c !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_midstream: y=%b c=%b ov=%b, required y=0000 c=0 ov=0", y, c, out_valid);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sel      = 3'b000;
        #1;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_not_shift();
        test_back_to_back();
        test_unknown_sel();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_alu_unit
`default_nettype wire
